// File: rtl/hdmi_video_pkg.sv
// Shared constants for the HDMI video path: BT.601 studio-range CSC
// coefficients, rounding/offset/clamp constants, blanking defaults and the
// fixed CSC pipeline depth that downstream/integration code may reference.
package hdmi_video_pkg;

  // Coefficient magnitudes (x256). Signs are applied in the sum stage:
  //   Y  = +KY_R  +KY_G  +KY_B
  //   Cb = -KCB_R -KCB_G +KCB_B
  //   Cr = +KCR_R -KCR_G -KCR_B
  localparam int KY_R  = 66;
  localparam int KY_G  = 129;
  localparam int KY_B  = 25;
  localparam int KCB_R = 38;
  localparam int KCB_G = 74;
  localparam int KCB_B = 112;
  localparam int KCR_R = 112;
  localparam int KCR_G = 94;
  localparam int KCR_B = 18;

  localparam int RND        = 128;
  localparam int OFS_Y      = 16;
  localparam int OFS_C      = 128;
  localparam int CLAMP_LO   = 16;
  localparam int CLAMP_Y_HI = 235;
  localparam int CLAMP_C_HI = 240;

  localparam logic [7:0] BLANK_Y_DEF = 8'd16;
  localparam logic [7:0] BLANK_C_DEF = 8'd128;

  localparam int CSC_LATENCY = 4;

  typedef enum logic {PH_CR = 1'b0, PH_CB = 1'b1} phase_e;

  // Round-to-nearest (floor of sum+128 >> 8), add offset, clamp to [16, hi].
  function automatic logic [7:0] csc_round(input logic signed [17:0] sum,
                                           input int ofs, input int hi);
    int v;
    v = ((int'(sum) + RND) >>> 8) + ofs;
    if (v < CLAMP_LO)  v = CLAMP_LO;
    else if (v > hi)   v = hi;
    return 8'(v);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// WIDTH x DEPTH shift register with synchronous active-low clear.
// Ports: clk, rst_n (sync, active-low), din[WIDTH], dout[WIDTH] = din delayed
// by DEPTH clocks. DEPTH must be >= 1.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/rgb_to_ycbcr422.sv
// RGB888 -> BT.601 studio-range YCbCr 4:2:2 (co-sited), 4-cycle pipeline.
// Ports: clk, rst_n (sync, active-low); rgb_r/g/b + hsync/vsync/de in;
// y (luma), c (Cb/Cr multiplexed per pixel), hsync/vsync/de out, all aligned.
// Stages: S1 products, S2 signed sums, S3 round/offset/clamp, S4 chroma mux.
module rgb_to_ycbcr422
  import hdmi_video_pkg::*;
#(
  parameter logic [7:0] BLANK_Y  = BLANK_Y_DEF,
  parameter logic [7:0] BLANK_C  = BLANK_C_DEF,
  parameter bit         CB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rgb_r,
  input  logic [7:0] rgb_g,
  input  logic [7:0] rgb_b,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  output logic [7:0] y,
  output logic [7:0] c,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out
);

  localparam phase_e START_PH = CB_FIRST ? PH_CB : PH_CR;

  function automatic logic [15:0] mul(input logic [7:0] a, input int k);
    return 16'(a) * 16'(k);
  endfunction

  function automatic logic signed [17:0] sx(input logic [15:0] p);
    return $signed({2'b00, p});
  endfunction

  // Product order: Y r/g/b, Cb r/g/b, Cr r/g/b (magnitudes only).
  logic [8:0][15:0]   prod_q, prod_d;
  logic signed [17:0] sum_y_q, sum_y_d, sum_cb_q, sum_cb_d, sum_cr_q, sum_cr_d;
  logic [7:0]         y3_q, y3_d, cb3_q, cb3_d, cr3_q, cr3_d;
  logic [7:0]         y_q, y_d, c_q, c_d, cr_hold_q, cr_hold_d;
  phase_e             phase_q, phase_d, cur_ph;
  // DE travelling with the datapath; vld_q[2] qualifies the S3 values.
  logic [2:0]         vld_q, vld_d;

  always_comb begin
    prod_d[0] = mul(rgb_r, KY_R);
    prod_d[1] = mul(rgb_g, KY_G);
    prod_d[2] = mul(rgb_b, KY_B);
    prod_d[3] = mul(rgb_r, KCB_R);
    prod_d[4] = mul(rgb_g, KCB_G);
    prod_d[5] = mul(rgb_b, KCB_B);
    prod_d[6] = mul(rgb_r, KCR_R);
    prod_d[7] = mul(rgb_g, KCR_G);
    prod_d[8] = mul(rgb_b, KCR_B);

    sum_y_d  = sx(prod_q[0]) + sx(prod_q[1]) + sx(prod_q[2]);
    sum_cb_d = sx(prod_q[5]) - sx(prod_q[3]) - sx(prod_q[4]);
    sum_cr_d = sx(prod_q[6]) - sx(prod_q[7]) - sx(prod_q[8]);

    y3_d  = csc_round(sum_y_q,  OFS_Y, CLAMP_Y_HI);
    cb3_d = csc_round(sum_cb_q, OFS_C, CLAMP_C_HI);
    cr3_d = csc_round(sum_cr_q, OFS_C, CLAMP_C_HI);

    vld_d = {vld_q[1:0], de_in};
  end

  // S4: de_out is the S4 DE, i.e. last cycle's S3 DE, so S3 DE high with
  // de_out low marks the first pixel of a line and restarts the phase.
  always_comb begin
    y_d       = BLANK_Y;
    c_d       = BLANK_C;
    phase_d   = phase_q;
    cr_hold_d = cr_hold_q;
    cur_ph    = (vld_q[2] && !de_out) ? START_PH : phase_q;
    if (vld_q[2]) begin
      y_d = y3_q;
      if (cur_ph == PH_CB) begin
        c_d       = cb3_q;
        cr_hold_d = cr3_q;
        phase_d   = PH_CR;
      end else begin
        c_d     = cr_hold_q;
        phase_d = PH_CB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q    <= '0;
      sum_y_q   <= '0;
      sum_cb_q  <= '0;
      sum_cr_q  <= '0;
      y3_q      <= '0;
      cb3_q     <= '0;
      cr3_q     <= '0;
      vld_q     <= '0;
      y_q       <= BLANK_Y;
      c_q       <= BLANK_C;
      cr_hold_q <= 8'(OFS_C);
      phase_q   <= START_PH;
    end else begin
      prod_q    <= prod_d;
      sum_y_q   <= sum_y_d;
      sum_cb_q  <= sum_cb_d;
      sum_cr_q  <= sum_cr_d;
      y3_q      <= y3_d;
      cb3_q     <= cb3_d;
      cr3_q     <= cr3_d;
      vld_q     <= vld_d;
      y_q       <= y_d;
      c_q       <= c_d;
      cr_hold_q <= cr_hold_d;
      phase_q   <= phase_d;
    end
  end

  sync_delay #(.WIDTH(3), .DEPTH(CSC_LATENCY)) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hsync_in, vsync_in, de_in}),
    .dout ({hsync_out, vsync_out, de_out})
  );

  assign y = y_q;
  assign c = c_q;

endmodule
